memory_stage: RTL
=================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter REG_W, default 5, register index width.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  execute-stage uop valid.
REQ-006 in_stall  out  1  stage cannot accept; upstream holds its uop.
REQ-007 in_rd  in  REG_W  destination register.
REQ-008 in_rd_val  in  XLEN  ALU result; effective address when in_is_ld or in_is_st.
REQ-009 in_rs2_val  in  XLEN  store data.
REQ-010 in_is_ld, in_is_st  in  1 each  load / store uop; never both set.
REQ-011 in_size  in  2  0=byte, 1=half, 2/3=word.
REQ-012 in_unsigned  in  1  zero-extend load result.
REQ-013 in_ex_valid  in  1; in_ex  in  4  pending exception and cause.
REQ-014 out_valid  out  1; out_stall  in  1  downstream handshake.
REQ-015 out_rd  out  REG_W; out_rd_val  out  XLEN; out_ex_valid  out  1; out_ex  out  4  result to writeback.
REQ-016 byp_r_valid  out  1; byp_r  out  REG_W; byp_r_val  out  XLEN  bypass to execute.
REQ-017 dmem_req_valid  out  1; dmem_req_ready  in  1; dmem_we  out  1; dmem_addr  out  XLEN; dmem_wdata  out  XLEN; dmem_wstrb  out  XLEN/8  memory request.
REQ-018 dmem_resp_valid  in  1; dmem_rdata  in  XLEN  load response (one per load request, any latency >=1 cycle after acceptance).

Function
REQ-019 FSM states IDLE, REQ, RESP, DONE; uop accepted only in IDLE.
REQ-020 in_stall = (state != IDLE) or (out_valid and out_stall).
REQ-021 Accept (in_valid and not in_stall): non-memory uop, or any uop with in_ex_valid, loads output register next cycle (1-cycle latency) and stays in IDLE.
REQ-022 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0, produces out_ex_valid=1, out_ex=4 (load) or 6 (store), no memory access, 1-cycle latency.
REQ-023 Aligned load/store on accept: capture uop and go to REQ; dmem_req_valid=1 only in REQ.
REQ-024 dmem_addr = address with low log2(XLEN/8) bits cleared; dmem_we = is_st.
REQ-025 dmem_wstrb: byte sets 1 bit at addr offset, half 2 bits, word all bits; dmem_wdata = store data replicated across lanes.
REQ-026 REQ with dmem_req_ready=1: store goes to DONE, load goes to RESP; otherwise hold REQ with all request fields stable.
REQ-027 RESP with dmem_resp_valid=1: select lane by addr offset, sign- or zero-extend per in_unsigned/size, store result, go to DONE.
REQ-028 DONE: when output register free (not out_valid or not out_stall), load it and go to IDLE next cycle.
REQ-029 Latency with ready/resp immediate and no out_stall: store 3 cycles accept-to-out_valid, load 4 cycles.
REQ-030 Stores and excepting uops drive out_rd=0.
REQ-031 Output register holds all out_* fields while out_valid and out_stall; otherwise out_valid clears when nothing completes.
REQ-032 byp_r_valid = out_valid and out_rd != 0 and not out_ex_valid; byp_r = out_rd; byp_r_val = out_rd_val.
REQ-033 dmem_resp_valid outside RESP is ignored.

Reset
REQ-034 rst forces state IDLE, out_valid=0, dmem_req_valid=0, byp_r_valid=0 and abandons any in-flight transaction; data registers need no reset.
REQ-035 in_stall=0 in the first cycle after reset release.

Verification
REQ-036 Non-memory uop: rd=3, rd_val=0x1234 -> next cycle out_valid=1, out_rd=3, byp_r_valid=1, byp_r_val=0x1234.
REQ-037 Load byte signed, addr=0x103, rdata=0x80FF_FF00 -> out_rd_val=0xFFFF_FF80, dmem_addr=0x100.
REQ-038 Store half, addr=0x202, data=0xBEEF -> wstrb=4'b1100, wdata=0xBEEF_BEEF, out_rd=0.
REQ-039 Load word, addr=0x6 -> out_ex_valid=1, out_ex=4, dmem_req_valid never asserted.
REQ-040 dmem_req_ready low for 3 cycles, then out_stall high for 2 cycles -> request fields stable, in_stall=1 throughout, exactly one out_valid result.
REQ-041 rst in RESP, then late dmem_resp_valid -> ignored, out_valid stays 0, next uop processed normally.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: issues data-memory requests for loads/stores and registers the writeback result.
// Latency: 1 cycle for non-memory, excepting or misaligned uops; 3 cycles for stores, 4 for loads.
// Backpressure: in_stall while a memory access is in flight or a held result is stalled downstream.
module memory_stage #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_stall,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [XLEN-1:0]     in_rd_val,
  input  logic [XLEN-1:0]     in_rs2_val,
  input  logic                in_is_ld,
  input  logic                in_is_st,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic                in_ex_valid,
  input  logic [3:0]          in_ex,
  output logic                out_valid,
  input  logic                out_stall,
  output logic [REG_W-1:0]    out_rd,
  output logic [XLEN-1:0]     out_rd_val,
  output logic                out_ex_valid,
  output logic [3:0]          out_ex,
  output logic                byp_r_valid,
  output logic [REG_W-1:0]    byp_r,
  output logic [XLEN-1:0]     byp_r_val,
  output logic                dmem_req_valid,
  input  logic                dmem_req_ready,
  output logic                dmem_we,
  output logic [XLEN-1:0]     dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  output logic [XLEN/8-1:0]   dmem_wstrb,
  input  logic                dmem_resp_valid,
  input  logic [XLEN-1:0]     dmem_rdata
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state_q, state_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [XLEN-1:0]   ldata_q, ldata_d;
  logic              is_st_q, is_st_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;

  logic              out_valid_q, out_valid_d;
  logic [REG_W-1:0]  out_rd_q, out_rd_d;
  logic [XLEN-1:0]   out_rd_val_q, out_rd_val_d;
  logic              out_ex_valid_q, out_ex_valid_d;
  logic [3:0]        out_ex_q, out_ex_d;

  logic              accept, out_free, misalign, is_mem;
  logic [OFF-1:0]    off;
  logic [XLEN-1:0]   lane, ext_mask, load_val;
  logic              ext_sign;

  assign off      = addr_q[OFF-1:0];
  assign out_free = !out_valid_q || !out_stall;
  assign in_stall = (state_q != IDLE) || (out_valid_q && out_stall);
  assign accept   = in_valid && !in_stall;
  assign is_mem   = in_is_ld || in_is_st;
  assign misalign = ((in_size == 2'd1) && in_rd_val[0]) ||
                    (in_size[1] && (in_rd_val[1:0] != 2'b00));

  // Request fields come straight from the captured uop so they stay stable while REQ waits.
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_we        = is_st_q;
  assign dmem_addr      = {addr_q[XLEN-1:OFF], {OFF{1'b0}}};

  // Store lane strobes and data replication by access size.
  always_comb begin
    case (size_q)
      2'd0: begin
        dmem_wstrb = NB'(1) << off;
        dmem_wdata = {NB{sdata_q[7:0]}};
      end
      2'd1: begin
        dmem_wstrb = NB'(3) << off;
        dmem_wdata = {(NB/2){sdata_q[15:0]}};
      end
      default: begin
        dmem_wstrb = '1;
        dmem_wdata = {(NB/4){sdata_q[31:0]}};
      end
    endcase
  end

  // Load lane select and sign/zero extension of the returned word.
  always_comb begin
    lane = dmem_rdata >> {off, 3'b000};
    case (size_q)
      2'd0:    begin ext_mask = XLEN'(8'hFF);         ext_sign = lane[7];  end
      2'd1:    begin ext_mask = XLEN'(16'hFFFF);      ext_sign = lane[15]; end
      default: begin ext_mask = XLEN'(32'hFFFF_FFFF); ext_sign = lane[31]; end
    endcase
    if (uns_q) ext_sign = 1'b0;
    load_val = (lane & ext_mask) | (ext_sign ? ~ext_mask : '0);
  end

  // Next-state, uop capture and output-register loading.
  always_comb begin
    state_d        = state_q;
    rd_d           = rd_q;
    addr_d         = addr_q;
    sdata_d        = sdata_q;
    ldata_d        = ldata_q;
    is_st_d        = is_st_q;
    size_d         = size_q;
    uns_d          = uns_q;
    out_valid_d    = out_valid_q && out_stall;
    out_rd_d       = out_rd_q;
    out_rd_val_d   = out_rd_val_q;
    out_ex_valid_d = out_ex_valid_q;
    out_ex_d       = out_ex_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_ex_valid) begin
            out_valid_d    = 1'b1;
            out_rd_d       = '0;
            out_rd_val_d   = in_rd_val;
            out_ex_valid_d = 1'b1;
            out_ex_d       = in_ex;
          end else if (is_mem && misalign) begin
            out_valid_d    = 1'b1;
            out_rd_d       = '0;
            out_rd_val_d   = in_rd_val;
            out_ex_valid_d = 1'b1;
            out_ex_d       = in_is_st ? 4'd6 : 4'd4;
          end else if (is_mem) begin
            rd_d    = in_rd;
            addr_d  = in_rd_val;
            sdata_d = in_rs2_val;
            is_st_d = in_is_st;
            size_d  = in_size;
            uns_d   = in_unsigned;
            state_d = REQ;
          end else begin
            out_valid_d    = 1'b1;
            out_rd_d       = in_rd;
            out_rd_val_d   = in_rd_val;
            out_ex_valid_d = 1'b0;
            out_ex_d       = 4'd0;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) state_d = is_st_q ? DONE : RESP;
      end
      RESP: begin
        if (dmem_resp_valid) begin
          ldata_d = load_val;
          state_d = DONE;
        end
      end
      default: begin
        if (out_free) begin
          out_valid_d    = 1'b1;
          out_rd_d       = is_st_q ? '0 : rd_q;
          out_rd_val_d   = is_st_q ? '0 : ldata_q;
          out_ex_valid_d = 1'b0;
          out_ex_d       = 4'd0;
          state_d        = IDLE;
        end
      end
    endcase
  end

  // Control state: reset abandons any in-flight access and drops the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Data registers carry no reset; they are qualified by state/out_valid.
  always_ff @(posedge clk) begin
    rd_q           <= rd_d;
    addr_q         <= addr_d;
    sdata_q        <= sdata_d;
    ldata_q        <= ldata_d;
    is_st_q        <= is_st_d;
    size_q         <= size_d;
    uns_q          <= uns_d;
    out_rd_q       <= out_rd_d;
    out_rd_val_q   <= out_rd_val_d;
    out_ex_valid_q <= out_ex_valid_d;
    out_ex_q       <= out_ex_d;
  end

  assign out_valid    = out_valid_q;
  assign out_rd       = out_rd_q;
  assign out_rd_val   = out_rd_val_q;
  assign out_ex_valid = out_ex_valid_q;
  assign out_ex       = out_ex_q;

  assign byp_r_valid = out_valid_q && (out_rd_q != '0) && !out_ex_valid_q;
  assign byp_r       = out_rd_q;
  assign byp_r_val   = out_rd_val_q;

endmodule
